// File: rtl/io_port_pkg.sv
// Shared types and constants for the I/O port sequencer.
// Holds the FSM state encoding and transfer direction codes.
package io_port_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    DONE
  } state_t;

  localparam logic IO_DIR_RD = 1'b0;
  localparam logic IO_DIR_WR = 1'b1;
  localparam int   W_DEF     = 8;

endpackage

// File: rtl/io_port_ctrl_if.sv
// CPU strobes and device handshake bundle for io_port_ctrl.
// master = the sequencer, slave = CPU side plus port devices.
interface io_port_ctrl_if
  import io_port_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int W      = W_DEF
);

  localparam int PW = $clog2(NPORTS);

  logic              io_enable;
  logic              io_dir;
  logic [PW-1:0]     port_sel;
  logic [W-1:0]      wdata;
  logic              stall;
  logic              done;
  logic [W-1:0]      rdata;
  logic              err_flag;
  logic [NPORTS*W-1:0] out_port;
  logic [NPORTS-1:0] out_valid;
  logic [NPORTS-1:0] out_ready;
  logic [W-1:0]      out_data;
  logic [NPORTS*W-1:0] in_data;
  logic [NPORTS-1:0] in_valid;
  logic [NPORTS-1:0] in_ack;

  modport master (
    input  io_enable, io_dir, port_sel, wdata,
    input  out_ready, in_data, in_valid,
    output stall, done, rdata, err_flag,
    output out_port, out_valid, out_data, in_ack
  );

  modport slave (
    output io_enable, io_dir, port_sel, wdata,
    output out_ready, in_data, in_valid,
    input  stall, done, rdata, err_flag,
    input  out_port, out_valid, out_data, in_ack
  );

endinterface

// File: rtl/io_wdog.sv
// Handshake watchdog: counts wait cycles since the last clear.
// expired is high once TIMEOUT-1 wait cycles have elapsed.
module io_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/io_port_ctrl.sv
// I/O port bank sequencer: one read/write at a time, stalls the CPU.
// Define IO_TIMEOUT_EN to build the handshake watchdog and err_flag.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int NPORTS  = 4,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  io_port_ctrl_if.master bus
);

  localparam int PW = $clog2(NPORTS);

  state_t              state;
  logic [PW-1:0]       sel;
  logic                done_q;
  logic [W-1:0]        rdata_q;
  logic [W-1:0]        data_q;
  logic [NPORTS*W-1:0] port_q;
  logic [NPORTS-1:0]   valid_q;
  logic [NPORTS-1:0]   ack;
  logic [W-1:0]        sel_in;
  logic                req;
  logic                waiting;
  logic                expired;

  assign req     = (state == IDLE) && bus.io_enable;
  assign waiting = (state == WR_WAIT) || (state == RD_WAIT);

  always_comb begin
    sel_in = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sel == PW'(i)) sel_in = bus.in_data[i*W +: W];
    end
  end

  always_comb begin
    ack = '0;
    if (state == RD_WAIT) ack[sel] = bus.in_valid[sel];
  end

`ifdef IO_TIMEOUT_EN
  logic err_q;

  io_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (req),
    .tick    (waiting),
    .expired (expired)
  );

  assign bus.err_flag = err_q;
`else
  assign expired      = 1'b0;
  assign bus.err_flag = 1'b0;
`endif

  // out_data doubles as the captured write data, so it is 0 outside WR_WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      data_q  <= '0;
      port_q  <= '0;
      valid_q <= '0;
`ifdef IO_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.io_enable) begin
            sel <= bus.port_sel;
            if (bus.io_dir == IO_DIR_WR) begin
              state   <= WR_WAIT;
              data_q  <= bus.wdata;
              valid_q <= '0;
              valid_q[bus.port_sel] <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (bus.out_ready[sel]) begin
            for (int i = 0; i < NPORTS; i++) begin
              if (sel == PW'(i)) port_q[i*W +: W] <= data_q;
            end
            valid_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b1;
            state   <= DONE;
          end else if (expired) begin
            valid_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b1;
            state   <= DONE;
`ifdef IO_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end
        end
        RD_WAIT: begin
          if (bus.in_valid[sel]) begin
            rdata_q <= sel_in;
            done_q  <= 1'b1;
            state   <= DONE;
          end else if (expired) begin
            rdata_q <= '0;
            done_q  <= 1'b1;
            state   <= DONE;
`ifdef IO_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall     = req || waiting;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.out_port  = port_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.in_ack    = ack;

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Sequencer for the processor's I/O port bank. It sits between the control unit's I/O strobes and up to NPORTS external devices. It accepts one read (port→register) or write (register/immediate→port) request at a time and runs a valid/ready handshake with the selected device. While the transfer is outstanding it stalls the CPU, then returns a one-cycle completion pulse with read data. Written values are held in per-port output latches.

## Interface
- NPORTS, 4, number of I/O ports; power of two, range 2..8
- W, 8, port data width
- TIMEOUT, 255, handshake wait limit in cycles; used only with the watchdog compiled in
- PW, $clog2(NPORTS), port select width (derived, not overridden)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- io_enable  in  1  I/O request from the control unit
- io_dir  in  1  1 = write port, 0 = read port
- port_sel  in  PW  target port
- wdata  in  W  write data (register or immediate, muxed upstream)
- stall  out  1  hold PC and instruction while high
- done  out  1  one-cycle completion pulse; register write-enable for reads
- rdata  out  W  read result; valid while done=1
- err_flag  out  1  sticky timeout error; cleared only by reset
- out_port  out  NPORTS*W  latched output values; port i = bits [i*W +: W]
- out_valid  out  NPORTS  write offer to port i
- out_ready  in  NPORTS  port i accepts the write
- out_data  out  W  shared write bus
- in_data  in  NPORTS*W  input port values
- in_valid  in  NPORTS  port i has data
- in_ack  out  NPORTS  port i data consumed

## Operation
- FSM states: IDLE, WR_WAIT, RD_WAIT, DONE.
- IDLE:
  - io_enable=1 → capture port_sel, io_dir and wdata.
  - Next state is WR_WAIT if io_dir=1, otherwise RD_WAIT.
- WR_WAIT:
  - out_valid[sel]=1; out_data = captured wdata.
  - When out_ready[sel]=1 at the edge → out_port[sel] ← data, go to DONE.
- RD_WAIT:
  - in_ack[sel] = in_valid[sel], combinational, high only in RD_WAIT.
  - When in_valid[sel]=1 at the edge → rdata ← in_data[sel], go to DONE.
- DONE: done=1, stall=0, then IDLE unconditionally.
  - io_enable is ignored in DONE, so the CPU advances and the request is never re-issued.
- stall = (IDLE & io_enable) | WR_WAIT | RD_WAIT.
- Non-selected ports always see out_valid=0 and in_ack=0.
- out_data is 0 outside WR_WAIT.
- rdata holds its last value outside DONE.
- Reset values (all outputs): state IDLE, stall=0 (given io_enable=0), done=0, rdata=0, err_flag=0, out_port=0, out_valid=0, in_ack=0, out_data=0.
- Reset mid-transfer: return to IDLE at the reset edge and drop the captured request. No done pulse; out_port is cleared.
- Changes to port_sel or wdata during a wait have no effect, because values are captured in IDLE.

## Timing
- Write, with ready already high: edge 1 IDLE→WR_WAIT, edge 2 →DONE, edge 3 →IDLE.
  - stall is high for 2 cycles; done appears in cycle 3.
  - out_port updates at edge 2.
- Read, with valid already high: same 3-cycle profile.
  - in_ack is high for exactly 1 cycle (the RD_WAIT cycle).
  - rdata is valid in the DONE cycle.
- Each additional wait cycle of the device adds exactly one stall cycle.
- Back-to-back requests: a new io_enable is accepted in the IDLE cycle following DONE. Minimum issue interval is 3 cycles.

## Configuration
- IO_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WR_WAIT/RD_WAIT and increments each wait cycle.
  - When the count reaches TIMEOUT-1 with no handshake: go to DONE and set err_flag. out_port is unchanged; rdata ← 0 for reads.
  - The abort happens at edge TIMEOUT after entry.
  - A handshake in the same cycle as the limit wins: normal completion, no error.
- IO_TIMEOUT_EN undefined:
  - No counter is built; waits are unbounded.
  - err_flag is tied to 0.
  - TIMEOUT is unused.

## Structure
- Shared package io_port_pkg holds:
  - the state enum (IDLE, WR_WAIT, RD_WAIT, DONE);
  - constants IO_DIR_RD=0 and IO_DIR_WR=1;
  - default width W_DEF=8.
- Sub-module io_wdog holds the timeout counter: inputs clear and tick, output expired.
  - It is instantiated only under IO_TIMEOUT_EN.

## Test plan
- Write 8'hA5 to port 2 with out_ready[2] tied high → out_valid=4'b0100 for one cycle, out_port[2]=8'hA5 after edge 2, stall high for 2 cycles, done in cycle 3.
- Read port 1 with in_data[1]=8'h3C and in_valid[1] raised 4 cycles late → 5 stall cycles, single in_ack pulse on bit 1, rdata=8'h3C with done.
- Two writes back-to-back (port 0 8'h11, port 3 8'h22) with io_enable held high through DONE → exactly two transfers, with no duplicate.
- Reset asserted while in WR_WAIT → next cycle: IDLE, out_valid=0, out_port=0, no done pulse.
- IO_TIMEOUT_EN, TIMEOUT=8, read port 0 with in_valid never high → done at edge 9 after request, rdata=0, err_flag=1 and held.
- IO_TIMEOUT_EN, handshake arriving exactly at the limit cycle → normal completion with err_flag=0.
